// File: rtl/uart_loader.sv
// uart_loader
// ------------------------------------------------------------------------
// Receive side of the program-load path. Bytes arriving from the UART
// receiver are packed big-endian into 32-bit words. The first word of a
// frame is the word count N; the following N words are written to
// instruction memory at consecutive word addresses starting at 0. Once
// the frame is complete, load_done rises and stays high until reset.
//
// Optional feature (macro UART_LOADER_CHECKSUM_EN):
//   When defined, an 8-bit running sum of all data bytes is kept, and
//   one checksum byte is expected after the last data word. load_ok
//   reports whether it matched (load_ok=1 for an empty frame).
//   When undefined, there is no checksum state and load_ok mirrors
//   load_done.
//
// Parameters:
//   ADDR_W     instruction memory address width in words
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   rx_data    received byte from the UART receiver
//   rx_valid   one-cycle strobe, rx_data valid this cycle
//   writeaddr  instruction memory word address (word counter mod 2**ADDR_W)
//   writedata  word to write
//   write_en   one-cycle write strobe
//   load_done  level, high once the frame is complete
//   load_ok    level, frame accepted
// ------------------------------------------------------------------------
module uart_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] writeaddr,
    output logic [31:0]       writedata,
    output logic              write_en,
    output logic              load_done,
    output logic              load_ok
);

`ifdef UART_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_DATA = 2'd1,
        S_CHK  = 2'd2,
        S_DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd3
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [1:0]          byteCnt_q, byteCnt_d;
    // Only the three most recent bytes need storing: the fourth byte is
    // combined with them combinationally the cycle it arrives, and the
    // oldest byte would be shifted out at that same edge anyway.
    logic [23:0]         shift_q, shift_d;
    logic [31:0]         len_q, len_d;
    logic [31:0]         wordCnt_q, wordCnt_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                wen_q, wen_d;
    logic                done_q, done_d;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
    logic                ok_q, ok_d;
`endif

    logic [31:0]         word;
    logic                wordDone;

    assign word     = {shift_q, rx_data};
    assign wordDone = rx_valid && (byteCnt_q == 2'd3);

    // Next-state logic. Every register holds by default; write_en is a
    // pulse so it defaults low.
    always_comb begin
        state_d   = state_q;
        byteCnt_d = byteCnt_q;
        shift_d   = shift_q;
        len_d     = len_q;
        wordCnt_d = wordCnt_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wen_d     = 1'b0;
        done_d    = done_q;
`ifdef UART_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
        ok_d      = ok_q;
`endif

        case (state_q)
            S_LEN: begin
                if (rx_valid) begin
                    shift_d   = word[23:0];
                    byteCnt_d = byteCnt_q + 2'd1;
                end
                if (wordDone) begin
                    len_d = word;
                    if (word == 32'd0) begin
                        // Empty frame: done is visible the cycle after
                        // the last length byte, and trivially accepted.
                        state_d = S_DONE;
                        done_d  = 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                        ok_d    = 1'b1;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (rx_valid) begin
                    shift_d   = word[23:0];
                    byteCnt_d = byteCnt_q + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                    sum_d     = sum_q + rx_data;
`endif
                end
                if (wordDone) begin
                    wen_d     = 1'b1;
                    wdata_d   = word;
                    waddr_d   = wordCnt_q[ADDR_W-1:0];
                    wordCnt_d = wordCnt_q + 32'd1;
                    if ((wordCnt_q + 32'd1) == len_q) begin
`ifdef UART_LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end

`ifdef UART_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (rx_valid) begin
                    ok_d    = (rx_data == sum_q);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
`endif

            S_DONE: begin
                // Arriving from DATA, the final write strobe is high in
                // the first DONE cycle; done rises one cycle after it.
                done_d = 1'b1;
            end

            default: begin
                state_d = S_LEN;
            end
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_LEN;
            byteCnt_q <= 2'd0;
            shift_q   <= 24'd0;
            len_q     <= 32'd0;
            wordCnt_q <= 32'd0;
            waddr_q   <= '0;
            wdata_q   <= 32'd0;
            wen_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q     <= 8'd0;
            ok_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            byteCnt_q <= byteCnt_d;
            shift_q   <= shift_d;
            len_q     <= len_d;
            wordCnt_q <= wordCnt_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            done_q    <= done_d;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
            ok_q      <= ok_d;
`endif
        end
    end

    assign writeaddr = waddr_q;
    assign writedata = wdata_q;
    assign write_en  = wen_q;
    assign load_done = done_q;
`ifdef UART_LOADER_CHECKSUM_EN
    assign load_ok   = ok_q;
`else
    assign load_ok   = done_q;
`endif

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader
// ------------------------------------------------------------------------
// Directed bench for uart_loader. Two instances share the same byte
// stream: dut uses the default address width, dutW uses ADDR_W=2 so that
// address wrap-around is visible. Expected writes are queued as frames
// are driven and popped by per-instance monitors as write_en pulses.
// Optional checksum test is compiled with UART_LOADER_CHECKSUM_EN.
// ------------------------------------------------------------------------
module tb_uart_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;

    logic [9:0]  writeaddr;
    logic [31:0] writedata;
    logic        write_en;
    logic        load_done;
    logic        load_ok;

    logic [1:0]  writeaddrW;
    logic [31:0] writedataW;
    logic        write_enW;
    logic        load_doneW;
    logic        load_okW;

    uart_loader dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .writeaddr (writeaddr),
        .writedata (writedata),
        .write_en  (write_en),
        .load_done (load_done),
        .load_ok   (load_ok)
    );

    uart_loader #(.ADDR_W(2)) dutW (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .writeaddr (writeaddrW),
        .writedata (writedataW),
        .write_en  (write_enW),
        .load_done (load_doneW),
        .load_ok   (load_okW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         expQ[$];
    wr_t         expQW[$];
    wr_t         eMain;
    wr_t         eW;

    int          nCompared = 0;
    int          nMismatched = 0;
    int          cyc = 0;
    int          lastCaptureEdge = -1;
    int          lastWriteCyc = -1;
    int          doneRiseCyc = -1;
    logic        prevDone = 1'b0;
    int          widx = 0;
    logic [31:0] frameWords[0:7];

    always @(posedge clk) cyc <= cyc + 1;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor for the default-width instance, including the
    // one-cycle write latency and the load_done rise point.
    always @(negedge clk) begin
        if (!rst && write_en === 1'b1) begin
            lastWriteCyc = cyc;
            checkOutput("write_expected", {31'd0, expQ.size() > 0}, 32'd1);
            if (expQ.size() > 0) begin
                eMain = expQ.pop_front();
                checkOutput("waddr", {22'd0, writeaddr}, {22'd0, eMain.addr});
                checkOutput("wdata", writedata, eMain.data);
                checkOutput("wlatency", cyc, lastCaptureEdge);
            end
        end
        if (load_done === 1'b1 && !prevDone) doneRiseCyc = cyc;
        prevDone = (load_done === 1'b1);
    end

    // Scoreboard monitor for the narrow-address instance.
    always @(negedge clk) begin
        if (!rst && write_enW === 1'b1) begin
            checkOutput("write_expected_w", {31'd0, expQW.size() > 0}, 32'd1);
            if (expQW.size() > 0) begin
                eW = expQW.pop_front();
                checkOutput("waddr_w", {30'd0, writeaddrW}, {22'd0, eW.addr});
                checkOutput("wdata_w", writedataW, eW.data);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data         = b;
        rx_valid        = 1'b1;
        lastCaptureEdge = cyc + 1;
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (n) @(posedge clk);
    endtask

    task automatic doReset();
        #1;
        rst      = 1'b1;
        rx_valid = 1'b0;
        #2;
        checkOutput("rst_writeaddr", {22'd0, writeaddr}, 32'd0);
        checkOutput("rst_writedata", writedata, 32'd0);
        checkOutput("rst_write_en", {31'd0, write_en}, 32'd0);
        checkOutput("rst_load_done", {31'd0, load_done}, 32'd0);
        checkOutput("rst_load_ok", {31'd0, load_ok}, 32'd0);
        expQ.delete();
        expQW.delete();
        widx         = 0;
        lastWriteCyc = -1;
        doneRiseCyc  = -1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input bit gap, output logic [7:0] sum);
        sum = 8'd0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(w[31-8*i -: 8]);
            sum = sum + w[31-8*i -: 8];
            if (gap) idle(1);
        end
    endtask

    // Drives a length word plus n data words from frameWords, queueing the
    // expected writes. With the checksum build, a checksum byte offset by
    // ckDelta follows the data (none for an empty frame).
    task automatic sendFrame(input int n, input bit gap, input logic [7:0] ckDelta);
        logic [7:0] s;
        logic [7:0] total;
        logic [31:0] nw;
        total = 8'd0;
        nw    = n;
        sendWord(nw, gap, s);
        for (int k = 0; k < n; k++) begin
            expQ.push_back('{addr: 10'(widx % 1024), data: frameWords[k]});
            expQW.push_back('{addr: 10'(widx % 4), data: frameWords[k]});
            widx++;
            sendWord(frameWords[k], gap, s);
            total = total + s;
        end
`ifdef UART_LOADER_CHECKSUM_EN
        if (n > 0) applyStimulus(total + ckDelta);
`else
        if (ckDelta != 8'd0 || total == 8'hxx) idle(0);
`endif
        idle(3);
    endtask

    task automatic waitDone(input string tag);
        int k;
        k = 0;
        while (load_done !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        checkOutput(tag, {31'd0, load_done}, 32'd1);
    endtask

    initial begin
        // N=2 frame with gaps between bytes.
        doReset();
        frameWords[0] = 32'hDEADBEEF;
        frameWords[1] = 32'h12345678;
        sendFrame(2, 1'b1, 8'd0);
        waitDone("n2_done");
        checkOutput("n2_queue_empty", expQ.size(), 32'd0);
        checkOutput("n2_done_edge", doneRiseCyc, lastWriteCyc + 1);
        checkOutput("n2_load_ok", {31'd0, load_ok}, 32'd1);

        // N=0 frame, then extra bytes that must be ignored.
        doReset();
        sendFrame(0, 1'b1, 8'd0);
        checkOutput("n0_done_edge", doneRiseCyc, lastCaptureEdge);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        idle(4);
        checkOutput("n0_no_write", lastWriteCyc, -1);
        checkOutput("n0_done_held", {31'd0, load_done}, 32'd1);
        checkOutput("n0_load_ok", {31'd0, load_ok}, 32'd1);

        // N=1 with strobes on eight consecutive cycles.
        doReset();
        frameWords[0] = 32'h01020304;
        sendFrame(1, 1'b0, 8'd0);
        waitDone("n1_done");
        checkOutput("n1_queue_empty", expQ.size(), 32'd0);
        checkOutput("n1_done_edge", doneRiseCyc, lastWriteCyc + 1);

        // Reset after 6 bytes of an N=3 frame, then a clean N=1 frame.
        doReset();
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h03);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        doReset();
        frameWords[0] = 32'hCAFEBABE;
        sendFrame(1, 1'b1, 8'd0);
        waitDone("rst_mid_done");
        checkOutput("rst_mid_queue_empty", expQ.size(), 32'd0);
        checkOutput("rst_mid_data_held", writedata, 32'hCAFEBABE);

        // N=5: the ADDR_W=2 instance wraps to address 0 on the 5th word.
        doReset();
        for (int k = 0; k < 5; k++) frameWords[k] = 32'hA5000000 + 32'(k * 32'h01010101);
        sendFrame(5, 1'b1, 8'd0);
        waitDone("wrap_done");
        checkOutput("wrap_queue_empty", expQ.size(), 32'd0);
        checkOutput("wrap_queue_empty_w", expQW.size(), 32'd0);
        checkOutput("wrap_done_w", {31'd0, load_doneW}, 32'd1);
        checkOutput("wrap_done_edge", doneRiseCyc, lastWriteCyc + 1);
        checkOutput("wrap_last_addr_w", {30'd0, writeaddrW}, 32'd0);

`ifdef UART_LOADER_CHECKSUM_EN
        // Checksum match: 01+02+03+04 = 0A.
        doReset();
        frameWords[0] = 32'h01020304;
        sendFrame(1, 1'b1, 8'd0);
        waitDone("ck_good_done");
        checkOutput("ck_good_ok", {31'd0, load_ok}, 32'd1);

        // Checksum mismatch: 0B sent.
        doReset();
        frameWords[0] = 32'h01020304;
        sendFrame(1, 1'b1, 8'd1);
        waitDone("ck_bad_done");
        checkOutput("ck_bad_ok", {31'd0, load_ok}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
